// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
package pipe_ctrl_pkg;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        MULTI = 1'b1
    } state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    // Register specifier width for a given datapath width (never below 1 bit).
    function automatic int rw_of(input int size);
        return (size <= 2) ? 1 : $clog2(size);
    endfunction

endpackage

// File: rtl/pipe_reg_match.sv
// One source-vs-destination comparator; register 0 never matches.
module pipe_reg_match
    import pipe_ctrl_pkg::*;
#(
    parameter int RW = rw_of(32)
) (
    input  logic          valid,
    input  logic          regwrite,
    input  logic [RW-1:0] wreg,
    input  logic [RW-1:0] src,
    input  logic          uses,
    output logic          match
);

    assign match = valid && regwrite && uses && (src != '0) && (wreg == src);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/bubble/flush/forwarding controller for a 5-stage pipeline.
// Define PIPE_FWD_EN to enable operand forwarding (load-use stalls only).
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int SIZE      = 32,
    parameter int RW        = rw_of(SIZE),
    parameter int MULTI_LAT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          id_valid,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic          id_uses_rs,
    input  logic          id_uses_rt,
    input  logic          ex_valid,
    input  logic [RW-1:0] ex_wreg,
    input  logic          ex_regwrite,
    input  logic          ex_memread,
    input  logic          ex_multi,
    input  logic          ex_redirect,
    input  logic          mem_valid,
    input  logic [RW-1:0] mem_wreg,
    input  logic          mem_regwrite,
    input  logic          wb_valid,
    input  logic [RW-1:0] wb_wreg,
    input  logic          wb_regwrite,
    output logic          pc_stall,
    output logic          if_id_stall,
    output logic          if_id_flush,
    output logic          id_ex_bubble,
    output logic          id_ex_hold,
    output logic          ex_mem_bubble,
    output logic [1:0]    fwd_a,
    output logic [1:0]    fwd_b,
    output logic          multi_done
);

    localparam int CW = (MULTI_LAT > 2) ? $clog2(MULTI_LAT - 1) : 1;

    // Stage index: 0 = EX, 1 = EX/MEM, 2 = MEM/WB
    logic [2:0]    stg_valid;
    logic [2:0]    stg_regwrite;
    logic [RW-1:0] stg_wreg [3];
    logic [2:0]    rs_hit;
    logic [2:0]    rt_hit;

    assign stg_valid    = {wb_valid, mem_valid, ex_valid};
    assign stg_regwrite = {wb_regwrite, mem_regwrite, ex_regwrite};
    assign stg_wreg[0]  = ex_wreg;
    assign stg_wreg[1]  = mem_wreg;
    assign stg_wreg[2]  = wb_wreg;

    for (genvar g = 0; g < 3; g++) begin : g_stage
        pipe_reg_match #(.RW(RW)) u_rs (
            .valid    (stg_valid[g]),
            .regwrite (stg_regwrite[g]),
            .wreg     (stg_wreg[g]),
            .src      (id_rs),
            .uses     (id_uses_rs),
            .match    (rs_hit[g])
        );
        pipe_reg_match #(.RW(RW)) u_rt (
            .valid    (stg_valid[g]),
            .regwrite (stg_regwrite[g]),
            .wreg     (stg_wreg[g]),
            .src      (id_rt),
            .uses     (id_uses_rt),
            .match    (rt_hit[g])
        );
    end

    logic       data_hazard;
    logic [1:0] fwd_a_c;
    logic [1:0] fwd_b_c;

`ifdef PIPE_FWD_EN
    assign data_hazard = id_valid && ex_memread && (rs_hit[0] || rt_hit[0]);
    assign fwd_a_c = rs_hit[1] ? FWD_MEM : (rs_hit[2] ? FWD_WB : FWD_RF);
    assign fwd_b_c = rt_hit[1] ? FWD_MEM : (rt_hit[2] ? FWD_WB : FWD_RF);
`else
    // Without write-through, any in-flight writer of a source must drain first.
    logic unused_memread;
    assign unused_memread = ex_memread;
    assign data_hazard = id_valid && ((|rs_hit) || (|rt_hit));
    assign fwd_a_c = FWD_RF;
    assign fwd_b_c = FWD_RF;
`endif

    state_t        state;
    state_t        nxt_state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] nxt_cnt;
    logic          done_q;
    logic          multi_exit;
    logic          pc_stall_c;
    logic          if_id_stall_c;
    logic          if_id_flush_c;
    logic          id_ex_bubble_c;
    logic          id_ex_hold_c;
    logic          ex_mem_bubble_c;

    assign multi_exit = (state == MULTI) && (cnt == '0);

    always_comb begin
        nxt_state       = state;
        nxt_cnt         = cnt;
        pc_stall_c      = 1'b0;
        if_id_stall_c   = 1'b0;
        if_id_flush_c   = 1'b0;
        id_ex_bubble_c  = 1'b0;
        id_ex_hold_c    = 1'b0;
        ex_mem_bubble_c = 1'b0;
        if (state == MULTI) begin
            pc_stall_c      = 1'b1;
            if_id_stall_c   = 1'b1;
            id_ex_hold_c    = 1'b1;
            ex_mem_bubble_c = 1'b1;
            if (cnt == '0) begin
                nxt_state = RUN;
            end else begin
                nxt_cnt = cnt - 1'b1;
            end
        end else if (ex_redirect) begin
            if_id_flush_c  = 1'b1;
            id_ex_bubble_c = 1'b1;
        end else if (ex_multi && ex_valid && !done_q) begin
            // The trigger cycle already holds EX, so it counts toward the latency.
            pc_stall_c      = 1'b1;
            if_id_stall_c   = 1'b1;
            id_ex_hold_c    = 1'b1;
            ex_mem_bubble_c = 1'b1;
            nxt_state       = MULTI;
            nxt_cnt         = CW'(MULTI_LAT - 2);
        end else if (data_hazard) begin
            pc_stall_c     = 1'b1;
            if_id_stall_c  = 1'b1;
            id_ex_bubble_c = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            cnt        <= '0;
            done_q     <= 1'b0;
            multi_done <= 1'b0;
        end else begin
            state      <= nxt_state;
            cnt        <= nxt_cnt;
            done_q     <= multi_exit;
            multi_done <= multi_exit;
        end
    end

    // Combinational outputs are forced low while reset is asserted.
    assign pc_stall      = rst_n && pc_stall_c;
    assign if_id_stall   = rst_n && if_id_stall_c;
    assign if_id_flush   = rst_n && if_id_flush_c;
    assign id_ex_bubble  = rst_n && id_ex_bubble_c;
    assign id_ex_hold    = rst_n && id_ex_hold_c;
    assign ex_mem_bubble = rst_n && ex_mem_bubble_c;
    assign fwd_a         = rst_n ? fwd_a_c : FWD_RF;
    assign fwd_b         = rst_n ? fwd_b_c : FWD_RF;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (works with or without PIPE_FWD_EN).
module tb_pipe_hazard_ctrl;

    localparam int RW = 5;
`ifdef PIPE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    localparam logic [5:0] C_NONE  = 6'b000000;
    localparam logic [5:0] C_DATA  = 6'b110100;
    localparam logic [5:0] C_MULTI = 6'b110011;
    localparam logic [5:0] C_REDIR = 6'b001100;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          id_valid, id_uses_rs, id_uses_rt;
    logic [RW-1:0] id_rs, id_rt, ex_wreg, mem_wreg, wb_wreg;
    logic          ex_valid, ex_regwrite, ex_memread, ex_multi, ex_redirect;
    logic          mem_valid, mem_regwrite, wb_valid, wb_regwrite;
    logic          pc_stall, if_id_stall, if_id_flush, id_ex_bubble, id_ex_hold, ex_mem_bubble;
    logic [1:0]    fwd_a, fwd_b;
    logic          multi_done;
    logic [5:0]    ctl;
    logic [3:0]    fwd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign ctl = {pc_stall, if_id_stall, if_id_flush, id_ex_bubble, id_ex_hold, ex_mem_bubble};
    assign fwd = {fwd_a, fwd_b};

    pipe_hazard_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_valid(ex_valid), .ex_wreg(ex_wreg), .ex_regwrite(ex_regwrite),
        .ex_memread(ex_memread), .ex_multi(ex_multi), .ex_redirect(ex_redirect),
        .mem_valid(mem_valid), .mem_wreg(mem_wreg), .mem_regwrite(mem_regwrite),
        .wb_valid(wb_valid), .wb_wreg(wb_wreg), .wb_regwrite(wb_regwrite),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble), .id_ex_hold(id_ex_hold), .ex_mem_bubble(ex_mem_bubble),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .multi_done(multi_done)
    );

    task automatic idle();
        id_valid = 0; id_rs = '0; id_rt = '0; id_uses_rs = 0; id_uses_rt = 0;
        ex_valid = 0; ex_wreg = '0; ex_regwrite = 0; ex_memread = 0; ex_multi = 0; ex_redirect = 0;
        mem_valid = 0; mem_wreg = '0; mem_regwrite = 0;
        wb_valid = 0; wb_wreg = '0; wb_regwrite = 0;
    endtask

    task automatic set_id(input logic [RW-1:0] rs, input logic [RW-1:0] rt);
        id_valid = 1; id_rs = rs; id_rt = rt; id_uses_rs = 1; id_uses_rt = 1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle();
        set_id(5, 7);
        ex_valid = 1; ex_wreg = 5; ex_regwrite = 1; ex_memread = 1; ex_multi = 1;
        mem_valid = 1; mem_wreg = 7; mem_regwrite = 1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (ctl !== C_NONE || fwd !== 4'b0000 || multi_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: ctl=%b fwd=%b md=%b, required ctl=%b fwd=0000 md=0", ctl, fwd, multi_done, C_NONE);
        end
        @(negedge clk);
        idle();
        rst_n = 1;
        #1;
        checks++;
        if (ctl !== C_NONE || multi_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: ctl=%b md=%b, required ctl=%b md=0", ctl, multi_done, C_NONE);
        end
    endtask

    task automatic test_load_use();
        @(negedge clk);
        idle();
        set_id(5, 7);
        ex_valid = 1; ex_wreg = 5; ex_regwrite = 1; ex_memread = 1;
        #1;
        checks++;
        if (ctl !== C_DATA || fwd_a !== 2'b00) begin
            errors++;
            $display("FAIL load_use_stall: ctl=%b fwd_a=%b, required ctl=%b fwd_a=00", ctl, fwd_a, C_DATA);
        end
        @(negedge clk);
        ex_valid = 0; ex_memread = 0; ex_regwrite = 0;
        wb_valid = 1; wb_wreg = 5; wb_regwrite = 1;
        #1;
        checks++;
        if (ctl !== (FWD ? C_NONE : C_DATA) || fwd_a !== (FWD ? 2'b01 : 2'b00)) begin
            errors++;
            $display("FAIL load_use_after: ctl=%b fwd_a=%b, required ctl=%b fwd_a=%b",
                     ctl, fwd_a, FWD ? C_NONE : C_DATA, FWD ? 2'b01 : 2'b00);
        end
    endtask

    task automatic test_fwd_priority();
        @(negedge clk);
        idle();
        set_id(1, 3);
        mem_valid = 1; mem_wreg = 3; mem_regwrite = 1;
        wb_valid = 1; wb_wreg = 3; wb_regwrite = 1;
        #1;
        checks++;
        if (ctl !== (FWD ? C_NONE : C_DATA) || fwd !== (FWD ? 4'b0010 : 4'b0000)) begin
            errors++;
            $display("FAIL fwd_priority: ctl=%b fwd=%b, required ctl=%b fwd=%b",
                     ctl, fwd, FWD ? C_NONE : C_DATA, FWD ? 4'b0010 : 4'b0000);
        end
        @(negedge clk);
        idle();
        set_id(4, 2);
        ex_valid = 1; ex_wreg = 4; ex_regwrite = 1;
        #1;
        checks++;
        if (ctl !== (FWD ? C_NONE : C_DATA) || fwd !== 4'b0000) begin
            errors++;
            $display("FAIL ex_alu_dep: ctl=%b fwd=%b, required ctl=%b fwd=0000", ctl, fwd, FWD ? C_NONE : C_DATA);
        end
        @(negedge clk);
        idle();
        set_id(9, 2);
        id_uses_rs = 0;
        ex_valid = 1; ex_wreg = 9; ex_regwrite = 1; ex_memread = 1;
        mem_valid = 1; mem_wreg = 9; mem_regwrite = 1;
        #1;
        checks++;
        if (ctl !== C_NONE || fwd !== 4'b0000) begin
            errors++;
            $display("FAIL unused_src: ctl=%b fwd=%b, required ctl=%b fwd=0000", ctl, fwd, C_NONE);
        end
    endtask

    task automatic test_r0();
        @(negedge clk);
        idle();
        set_id(0, 0);
        ex_valid = 1; ex_wreg = 0; ex_regwrite = 1; ex_memread = 1;
        mem_valid = 1; mem_wreg = 0; mem_regwrite = 1;
        wb_valid = 1; wb_wreg = 0; wb_regwrite = 1;
        #1;
        checks++;
        if (ctl !== C_NONE || fwd !== 4'b0000) begin
            errors++;
            $display("FAIL r0_no_hazard: ctl=%b fwd=%b, required ctl=%b fwd=0000", ctl, fwd, C_NONE);
        end
    endtask

    task automatic test_nofwd_stall();
        @(negedge clk);
        idle();
        set_id(9, 1);
        wb_valid = 1; wb_wreg = 9; wb_regwrite = 1;
        #1;
        checks++;
        if (ctl !== (FWD ? C_NONE : C_DATA) || fwd_a !== (FWD ? 2'b01 : 2'b00)) begin
            errors++;
            $display("FAIL wb_dep: ctl=%b fwd_a=%b, required ctl=%b fwd_a=%b",
                     ctl, fwd_a, FWD ? C_NONE : C_DATA, FWD ? 2'b01 : 2'b00);
        end
        @(negedge clk);
        idle();
        set_id(9, 1);
        mem_valid = 1; mem_wreg = 9; mem_regwrite = 1;
        #1;
        checks++;
        if (ctl !== (FWD ? C_NONE : C_DATA) || fwd_a !== (FWD ? 2'b10 : 2'b00)) begin
            errors++;
            $display("FAIL mem_dep: ctl=%b fwd_a=%b, required ctl=%b fwd_a=%b",
                     ctl, fwd_a, FWD ? C_NONE : C_DATA, FWD ? 2'b10 : 2'b00);
        end
        @(negedge clk);
        mem_regwrite = 0;
        #1;
        checks++;
        if (ctl !== C_NONE || fwd_a !== 2'b00) begin
            errors++;
            $display("FAIL no_regwrite: ctl=%b fwd_a=%b, required ctl=%b fwd_a=00", ctl, fwd_a, C_NONE);
        end
    endtask

    task automatic test_multi();
        @(negedge clk);
        idle();
        set_id(1, 2);
        ex_valid = 1; ex_multi = 1; ex_regwrite = 1; ex_wreg = 8;
        #1;
        checks++;
        if (ctl !== C_MULTI || multi_done !== 1'b0) begin
            errors++;
            $display("FAIL multi_trigger: ctl=%b md=%b, required ctl=%b md=0", ctl, multi_done, C_MULTI);
        end
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            ex_redirect = (i == 2);
            #1;
            checks++;
            if (ctl !== C_MULTI || multi_done !== 1'b0) begin
                errors++;
                $display("FAIL multi_hold[%0d]: ctl=%b md=%b, required ctl=%b md=0", i, ctl, multi_done, C_MULTI);
            end
        end
        @(negedge clk);
        ex_redirect = 0;
        #1;
        checks++;
        if (ctl !== C_NONE || multi_done !== 1'b1) begin
            errors++;
            $display("FAIL multi_done_no_retrigger: ctl=%b md=%b, required ctl=%b md=1", ctl, multi_done, C_NONE);
        end
        @(negedge clk);
        ex_multi = 0;
        #1;
        checks++;
        if (ctl !== C_NONE || multi_done !== 1'b0) begin
            errors++;
            $display("FAIL multi_done_pulse_end: ctl=%b md=%b, required ctl=%b md=0", ctl, multi_done, C_NONE);
        end
    endtask

    task automatic test_redirect();
        @(negedge clk);
        idle();
        set_id(5, 7);
        ex_valid = 1; ex_wreg = 5; ex_regwrite = 1; ex_memread = 1; ex_redirect = 1;
        #1;
        checks++;
        if (ctl !== C_REDIR) begin
            errors++;
            $display("FAIL redirect_over_hazard: ctl=%b, required %b", ctl, C_REDIR);
        end
        @(negedge clk);
        idle();
        set_id(1, 2);
        ex_valid = 1; ex_multi = 1; ex_redirect = 1;
        #1;
        checks++;
        if (ctl !== C_REDIR) begin
            errors++;
            $display("FAIL redirect_over_multi: ctl=%b, required %b", ctl, C_REDIR);
        end
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (ctl !== C_NONE) begin
            errors++;
            $display("FAIL redirect_no_multi_entry: ctl=%b, required %b", ctl, C_NONE);
        end
    endtask

    task automatic test_reset_mid_multi();
        @(negedge clk);
        idle();
        ex_valid = 1; ex_multi = 1;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (ctl !== C_MULTI) begin
            errors++;
            $display("FAIL mid_multi_pre: ctl=%b, required %b", ctl, C_MULTI);
        end
        rst_n = 0;
        #1;
        checks++;
        if (ctl !== C_NONE || fwd !== 4'b0000 || multi_done !== 1'b0) begin
            errors++;
            $display("FAIL mid_multi_reset: ctl=%b fwd=%b md=%b, required all 0", ctl, fwd, multi_done);
        end
        @(negedge clk);
        idle();
        rst_n = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (ctl !== C_NONE || multi_done !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_run[%0d]: ctl=%b md=%b, required ctl=%b md=0", i, ctl, multi_done, C_NONE);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_fwd_priority();
        test_r0();
        test_nofwd_stall();
        test_multi();
        test_redirect();
        test_reset_mid_multi();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
